// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the architectural PC, issues one imem request at a time,
// and presents {pc, inst} to decode with late-redirect handling.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [31:0]      imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [31:0]      imem_resp_data,
    output logic             if_valid,
    input  logic             id_ready,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_inst,
    output logic [31:0]      pc_add4,
    input  logic [31:0]      npc_in,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] discard_cnt
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               kill_q, kill_d;
    logic               if_valid_q, if_valid_d;
    logic [31:0]        if_pc_q, if_pc_d;
    logic [31:0]        if_inst_q, if_inst_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               drop;
    logic [31:0]        redir_al;
    logic [31:0]        npc_al;

    assign accept   = imem_req_valid & imem_req_ready;
    assign drop     = kill_q | redirect_valid;
    assign redir_al = redirect_pc & 32'hFFFF_FFFC;
    assign npc_al   = npc_in & 32'hFFFF_FFFC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: if (accept) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_resp_valid) state_d = drop ? S_FETCH : S_HOLD;
            end
            S_HOLD: begin
                if (redirect_valid || id_ready) state_d = S_FETCH;
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        imem_req_valid = (state_q == S_FETCH);
    end

    // A redirect always wins; a response racing a redirect is counted as discarded.
    always_comb begin
        pc_d       = pc_q;
        kill_d     = kill_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            S_BOOT: begin
                if (redirect_valid) pc_d = redir_al;
            end
            S_FETCH: begin
                if (redirect_valid) pc_d = redir_al;
                if (accept) kill_d = redirect_valid;
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (drop) begin
                        kill_d = 1'b0;
                        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                        if (redirect_valid) pc_d = redir_al;
                    end else begin
                        if_inst_d  = imem_resp_data;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                    pc_d   = redir_al;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    pc_d       = redir_al;
                end else if (id_ready) begin
                    if_valid_d = 1'b0;
                    pc_d       = npc_al;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= RESET_PC;
            if_inst_q  <= 32'h0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_req_addr = pc_q;
    assign if_valid      = if_valid_q;
    assign if_pc         = if_pc_q;
    assign if_inst       = if_inst_q;
    assign pc_add4       = if_pc_q + 32'd4;
    assign discard_cnt   = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic
// against a transaction-level model of the fetch path.
module tb_pc_fetch_unit;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [31:0]   imem_req_addr;
    logic          imem_resp_valid;
    logic [31:0]   imem_resp_data;
    logic          if_valid;
    logic          id_ready;
    logic [31:0]   if_pc;
    logic [31:0]   if_inst;
    logic [31:0]   pc_add4;
    logic [31:0]   npc_in;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] discard_cnt;

    int errs = 0;
    int checks = 0;

    logic        pend;
    int          pcnt;
    logic [31:0] paddr;
    int          mem_lat;

    pc_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .CNT_W   (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .if_valid       (if_valid),
        .id_ready       (id_ready),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .pc_add4        (pc_add4),
        .npc_in         (npc_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .discard_cnt    (discard_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock step, with the instruction memory behaviour applied after the edge.
    task automatic cyc();
        logic        acc;
        logic [31:0] a;
        acc = !rst && imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (acc) begin
                pend  = 1'b1;
                pcnt  = mem_lat;
                paddr = a;
            end
            if (pend) begin
                if (pcnt <= 1) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(paddr);
                    pend = 1'b0;
                end else begin
                    pcnt--;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;
        id_ready = 1'b0;
        npc_in = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        pend = 1'b0;
        pcnt = 0;
        paddr = 32'h0;
        mem_lat = 1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errs++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid);
        end
        checks++;
        if (if_valid !== 1'b0) begin
            errs++; $display("FAIL rst_if_valid got %b want 0", if_valid);
        end
        checks++;
        if (if_pc !== 32'h0 || if_inst !== 32'h0) begin
            errs++; $display("FAIL rst_if got pc=%h inst=%h want 0/0", if_pc, if_inst);
        end
        checks++;
        if (discard_cnt !== '0 || pc_add4 !== 32'h4 || imem_req_addr !== 32'h0) begin
            errs++;
            $display("FAIL rst_misc got cnt=%0d add4=%h addr=%h want 0/4/0",
                     discard_cnt, pc_add4, imem_req_addr);
        end
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errs++; $display("FAIL boot_idle got %b want 0", imem_req_valid);
        end
    endtask

    task automatic test_sequence();
        logic        exp_v;
        logic [31:0] exp_pc;
        id_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            npc_in = pc_add4;
            exp_v  = (c > 0) && (c % 3 == 0);
            exp_pc = 32'((c / 3 - 1) * 4);
            checks++;
            if (if_valid !== exp_v) begin
                errs++; $display("FAIL seq_valid c=%0d got %b want %b", c, if_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (if_pc !== exp_pc || if_inst !== mem_word(exp_pc)) begin
                    errs++;
                    $display("FAIL seq_pc c=%0d got %h/%h want %h/%h",
                             c, if_pc, if_inst, exp_pc, mem_word(exp_pc));
                end
            end
            checks++;
            if (imem_req_valid !== (c % 3 == 1)) begin
                errs++; $display("FAIL seq_req c=%0d got %b", c, imem_req_valid);
            end
            if (c % 3 == 1) begin
                checks++;
                if (imem_req_addr !== 32'((c / 3) * 4)) begin
                    errs++;
                    $display("FAIL seq_addr c=%0d got %h want %h",
                             c, imem_req_addr, 32'((c / 3) * 4));
                end
            end
            cyc();
        end
    endtask

    task automatic test_npc();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if_valid && if_pc == 32'h10) begin
                found = 1'b1;
                break;
            end
            npc_in = pc_add4;
            cyc();
        end
        checks++;
        if (!found) begin
            errs++; $display("FAIL npc_reach got if_pc=%h want hold at 00000010", if_pc);
        end
        npc_in = 32'h40;
        cyc();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
            errs++;
            $display("FAIL npc_addr got v=%b addr=%h want 1/00000040",
                     imem_req_valid, imem_req_addr);
        end
        cyc();
        cyc();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_inst !== mem_word(32'h40)) begin
            errs++;
            $display("FAIL npc_if got v=%b pc=%h inst=%h want 1/00000040/%h",
                     if_valid, if_pc, if_inst, mem_word(32'h40));
        end
    endtask

    task automatic test_redirect_wait();
        npc_in = 32'h44;
        mem_lat = 2;
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        cyc();
        redirect_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_resp_valid !== 1'b1) begin
            errs++; $display("FAIL rw_resp got if_valid=%b resp=%b want 0/1", if_valid, imem_resp_valid);
        end
        cyc();
        mem_lat = 1;
        checks++;
        if (discard_cnt !== CW'(1)) begin
            errs++; $display("FAIL rw_cnt got %0d want 1", discard_cnt);
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80 || if_valid !== 1'b0) begin
            errs++;
            $display("FAIL rw_addr got v=%b addr=%h if_valid=%b want 1/00000080/0",
                     imem_req_valid, imem_req_addr, if_valid);
        end
    endtask

    task automatic test_redirect_hold();
        cyc();
        cyc();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h80) begin
            errs++; $display("FAIL rh_hold got v=%b pc=%h want 1/00000080", if_valid, if_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        id_ready = 1'b1;
        npc_in = 32'h200;
        cyc();
        redirect_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            errs++;
            $display("FAIL rh_redir got if_valid=%b v=%b addr=%h want 0/1/00000100",
                     if_valid, imem_req_valid, imem_req_addr);
        end
        checks++;
        if (discard_cnt !== CW'(1)) begin
            errs++; $display("FAIL rh_cnt got %0d want 1", discard_cnt);
        end
    endtask

    task automatic test_redirect_stall();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h2C3;
        cyc();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2C0) begin
            errs++; $display("FAIL rs_first got v=%b addr=%h want 1/000002c0", imem_req_valid, imem_req_addr);
        end
        redirect_pc = 32'h103;
        cyc();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
                errs++;
                $display("FAIL rs_hold i=%0d got v=%b addr=%h want 1/00000100",
                         i, imem_req_valid, imem_req_addr);
            end
            if (i < 2) cyc();
        end
        imem_req_ready = 1'b1;
        cyc();
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errs++; $display("FAIL rs_wait got %b want 0", imem_req_valid);
        end
        cyc();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== mem_word(32'h100) ||
            pc_add4 !== 32'h104) begin
            errs++;
            $display("FAIL rs_if got v=%b pc=%h inst=%h add4=%h want 1/00000100/%h/00000104",
                     if_valid, if_pc, if_inst, pc_add4, mem_word(32'h100));
        end
    endtask

    task automatic test_reset_wait();
        id_ready = 1'b1;
        npc_in = 32'h20;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || discard_cnt !== '0 ||
            if_pc !== 32'h0) begin
            errs++;
            $display("FAIL rwt_rst got v=%b if_valid=%b cnt=%0d pc=%h want 0/0/0/0",
                     imem_req_valid, if_valid, discard_cnt, if_pc);
        end
        cyc();
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errs++; $display("FAIL rwt_boot got %b want 0", imem_req_valid);
        end
        cyc();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || discard_cnt !== '0) begin
            errs++;
            $display("FAIL rwt_fetch got v=%b addr=%h cnt=%0d want 1/0/0",
                     imem_req_valid, imem_req_addr, discard_cnt);
        end
    endtask

    task automatic test_random();
        logic          boot, outs, killed, present, fetch;
        logic [31:0]   exp_pc, out_addr, pres_pc, pres_inst;
        logic [CW-1:0] exp_disc;
        for (int seg = 0; seg < 4; seg++) begin
            rst = 1'b1;
            redirect_valid = 1'b0;
            cyc();
            rst = 1'b0;
            #1;
            boot = 1'b1; outs = 1'b0; killed = 1'b0; present = 1'b0;
            exp_pc = 32'h0; out_addr = 32'h0; pres_pc = 32'h0; pres_inst = 32'h0;
            exp_disc = '0;
            for (int n = 0; n < 700; n++) begin
                imem_req_ready = ($urandom_range(3) != 0);
                mem_lat        = $urandom_range(3, 1);
                redirect_valid = ($urandom_range(9) == 0);
                redirect_pc    = $urandom;
                id_ready       = 1'($urandom_range(1));
                case ($urandom_range(3))
                    0: npc_in = 32'h0;
                    1: npc_in = $urandom;
                    default: npc_in = pc_add4;
                endcase
                fetch = !boot && !outs && !present;
                checks++;
                if (imem_req_valid !== fetch) begin
                    errs++; $display("FAIL rnd_req n=%0d got %b want %b", n, imem_req_valid, fetch);
                end
                if (fetch) begin
                    checks++;
                    if (imem_req_addr !== exp_pc) begin
                        errs++; $display("FAIL rnd_addr n=%0d got %h want %h", n, imem_req_addr, exp_pc);
                    end
                end
                checks++;
                if (if_valid !== present) begin
                    errs++; $display("FAIL rnd_ifv n=%0d got %b want %b", n, if_valid, present);
                end
                if (present) begin
                    checks++;
                    if (if_pc !== pres_pc || if_inst !== pres_inst || pc_add4 !== pres_pc + 32'd4) begin
                        errs++;
                        $display("FAIL rnd_if n=%0d got %h/%h/%h want %h/%h/%h", n,
                                 if_pc, if_inst, pc_add4, pres_pc, pres_inst, pres_pc + 32'd4);
                    end
                end
                checks++;
                if (discard_cnt !== exp_disc) begin
                    errs++; $display("FAIL rnd_cnt n=%0d got %0d want %0d", n, discard_cnt, exp_disc);
                end
                if (boot) begin
                    boot = 1'b0;
                    if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
                end else if (fetch) begin
                    if (imem_req_ready) begin
                        outs = 1'b1;
                        killed = redirect_valid;
                        out_addr = exp_pc;
                    end
                    if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
                end else if (outs) begin
                    if (imem_resp_valid) begin
                        outs = 1'b0;
                        if (killed || redirect_valid) begin
                            if (exp_disc != '1) exp_disc = exp_disc + 1'b1;
                            killed = 1'b0;
                        end else begin
                            present = 1'b1;
                            pres_pc = out_addr;
                            pres_inst = mem_word(out_addr);
                        end
                    end else if (redirect_valid) begin
                        killed = 1'b1;
                    end
                    if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
                end else begin
                    if (redirect_valid) begin
                        present = 1'b0;
                        exp_pc = redirect_pc & 32'hFFFF_FFFC;
                    end else if (id_ready) begin
                        present = 1'b0;
                        exp_pc = npc_in & 32'hFFFF_FFFC;
                    end
                end
                cyc();
            end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_npc();
        test_redirect_wait();
        test_redirect_hold();
        test_redirect_stall();
        test_reset_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
